// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Multi-cycle control sequencer for the 16-bit MIPS core. It walks the shared
// datapath (single memory port, one ALU, register file) through
// FETCH / DECODE / EXECUTE / MEM / WB for each 3-bit opcode. It stalls on the
// memory ready handshake and raises a sticky bus error on a memory timeout.
//
// Parameters
//   MEM_TIMEOUT  wait cycles allowed in FETCH / MEM_RD / MEM_WR before ERR (0 = never)
//   TO_W         timeout counter width (MEM_TIMEOUT < 2**TO_W)
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   opcode                     IR[15:13], sampled only in DECODE
//   zero                       ALU zero flag (branch condition)
//   mem_ready                  memory completes the access this cycle
//   stall                      debug/host freeze request
//   pc_write, pc_write_cond    PC load (unconditional / if zero)
//   pc_en                      pc_write | (pc_write_cond & zero)
//   pc_src, i_or_d, ir_write   PC source, address source, IR load
//   mem_read, mem_write        memory strobes
//   reg_write, reg_dst         register write enable / destination select
//   mem_to_reg                 write-back data select
//   alu_src_a, alu_src_b       ALU operand selects
//   alu_op                     ALU function select
//   instr_done                 one-cycle pulse in the final state of an instruction
//   bus_err                    sticky memory-timeout error
//   state_o                    current state (debug)
//
// Optional feature: define PERF_CNT_EN to add cycle_cnt / instr_cnt outputs.
//
// Moore outputs are registered from the next-state decode so they line up
// with state_reg. The handshake-dependent terms (FETCH ir_write/pc_write,
// MEM_WR instr_done) and the stall gating stay combinational because they
// must react to mem_ready / stall in the same cycle.

module multicycle_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    input  logic        stall,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_en,
    output logic [1:0]  pc_src,
    output logic        i_or_d,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        instr_done,
    output logic        bus_err,
`ifdef PERF_CNT_EN
    output logic [3:0]  state_o,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`else
    output logic [3:0]  state_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC_R   = 4'd7,
        S_R_WB     = 4'd8,
        S_EXEC_I   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_ERR      = 4'd14
    } state_t;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_SLTI = 3'b001;
    localparam logic [2:0] OP_J    = 3'b010;
    localparam logic [2:0] OP_JAL  = 3'b011;
    localparam logic [2:0] OP_LW   = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_ADDI = 3'b111;

    state_t            state_reg, state_next;
    logic [2:0]        opcode_reg, opcode_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next, to_cnt_inc;
    logic              mem_wait, timeout_hit;

    // Registered Moore outputs and their next-state decode
    logic       pc_write_reg, pc_write_next;
    logic       pc_write_cond_reg, pc_write_cond_next;
    logic [1:0] pc_src_reg, pc_src_next;
    logic       i_or_d_reg, i_or_d_next;
    logic       mem_read_reg, mem_read_next;
    logic       mem_write_reg, mem_write_next;
    logic       reg_write_reg, reg_write_next;
    logic [1:0] reg_dst_reg, reg_dst_next;
    logic [1:0] mem_to_reg_reg, mem_to_reg_next;
    logic       alu_src_a_reg, alu_src_a_next;
    logic [1:0] alu_src_b_reg, alu_src_b_next;
    logic [1:0] alu_op_reg, alu_op_next;
    logic       instr_done_reg, instr_done_next;
    logic       bus_err_reg, bus_err_next;

    // A wait cycle is an unstalled cycle in a memory state without mem_ready.
    assign mem_wait    = ((state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                          (state_reg == S_MEM_WR)) && !mem_ready && !stall;
    assign to_cnt_inc  = to_cnt_reg + TO_W'(1);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_wait &&
                         (to_cnt_inc == TO_W'(MEM_TIMEOUT));

    always_comb begin
        state_next  = state_reg;
        opcode_next = opcode_reg;
        to_cnt_next = to_cnt_reg;

        if (state_reg > S_ERR) begin
            state_next = S_IDLE;
        end else if (!stall) begin
            case (state_reg)
                S_IDLE:   state_next = S_FETCH;
                S_FETCH:  if (mem_ready) state_next = S_DECODE;
                          else if (timeout_hit) state_next = S_ERR;
                S_DECODE: begin
                    opcode_next = opcode;
                    case (opcode)
                        OP_LW, OP_SW:     state_next = S_MEM_ADDR;
                        OP_R:             state_next = S_EXEC_R;
                        OP_ADDI, OP_SLTI: state_next = S_EXEC_I;
                        OP_BEQ:           state_next = S_BRANCH;
                        OP_J:             state_next = S_JUMP;
                        OP_JAL:           state_next = S_JAL;
                    endcase
                end
                // Only lw/sw reach MEM_ADDR, so the latched opcode picks the direction.
                S_MEM_ADDR: state_next = (opcode_reg == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (mem_ready) state_next = S_MEM_WB;
                            else if (timeout_hit) state_next = S_ERR;
                S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
                            else if (timeout_hit) state_next = S_ERR;
                S_EXEC_R:   state_next = S_R_WB;
                S_EXEC_I:   state_next = S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL:
                            state_next = S_FETCH;
                S_ERR:      state_next = S_ERR;
                default:    state_next = S_IDLE;
            endcase

            // Any state change clears the counter, which covers every entry
            // into a memory state; it only advances on wait cycles.
            if (state_next != state_reg) to_cnt_next = '0;
            else if (mem_wait)           to_cnt_next = to_cnt_inc;
        end

        // Moore output decode of the state being entered
        pc_write_next      = 1'b0;
        pc_write_cond_next = 1'b0;
        pc_src_next        = 2'b00;
        i_or_d_next        = 1'b0;
        mem_read_next      = 1'b0;
        mem_write_next     = 1'b0;
        reg_write_next     = 1'b0;
        reg_dst_next       = 2'b00;
        mem_to_reg_next    = 2'b00;
        alu_src_a_next     = 1'b0;
        alu_src_b_next     = 2'b00;
        alu_op_next        = 2'b00;
        instr_done_next    = 1'b0;
        bus_err_next       = 1'b0;
        case (state_next)
            S_FETCH:    begin mem_read_next = 1'b1; alu_src_b_next = 2'b01; alu_op_next = 2'b11; end
            S_DECODE:   begin alu_src_b_next = 2'b10; alu_op_next = 2'b11; end
            S_MEM_ADDR: begin alu_src_a_next = 1'b1; alu_src_b_next = 2'b10; alu_op_next = 2'b11; end
            S_MEM_RD:   begin mem_read_next = 1'b1; i_or_d_next = 1'b1; end
            S_MEM_WB:   begin reg_write_next = 1'b1; mem_to_reg_next = 2'b01; instr_done_next = 1'b1; end
            S_MEM_WR:   begin mem_write_next = 1'b1; i_or_d_next = 1'b1; end
            S_EXEC_R:   begin alu_src_a_next = 1'b1; end
            S_R_WB:     begin reg_write_next = 1'b1; reg_dst_next = 2'b01; instr_done_next = 1'b1; end
            S_EXEC_I: begin
                alu_src_a_next = 1'b1;
                alu_src_b_next = 2'b10;
                alu_op_next    = (opcode_next == OP_SLTI) ? 2'b10 : 2'b11;
            end
            S_I_WB:     begin reg_write_next = 1'b1; instr_done_next = 1'b1; end
            S_BRANCH: begin
                alu_src_a_next     = 1'b1;
                alu_op_next        = 2'b01;
                pc_write_cond_next = 1'b1;
                pc_src_next        = 2'b01;
                instr_done_next    = 1'b1;
            end
            S_JUMP:     begin pc_write_next = 1'b1; pc_src_next = 2'b10; instr_done_next = 1'b1; end
            S_JAL: begin
                pc_write_next   = 1'b1;
                pc_src_next     = 2'b10;
                reg_write_next  = 1'b1;
                reg_dst_next    = 2'b10;
                mem_to_reg_next = 2'b10;
                instr_done_next = 1'b1;
            end
            S_ERR:      bus_err_next = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg         <= S_IDLE;
            opcode_reg        <= 3'b000;
            to_cnt_reg        <= '0;
            pc_write_reg      <= 1'b0;
            pc_write_cond_reg <= 1'b0;
            pc_src_reg        <= 2'b00;
            i_or_d_reg        <= 1'b0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            reg_write_reg     <= 1'b0;
            reg_dst_reg       <= 2'b00;
            mem_to_reg_reg    <= 2'b00;
            alu_src_a_reg     <= 1'b0;
            alu_src_b_reg     <= 2'b00;
            alu_op_reg        <= 2'b00;
            instr_done_reg    <= 1'b0;
            bus_err_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            opcode_reg        <= opcode_next;
            to_cnt_reg        <= to_cnt_next;
            pc_write_reg      <= pc_write_next;
            pc_write_cond_reg <= pc_write_cond_next;
            pc_src_reg        <= pc_src_next;
            i_or_d_reg        <= i_or_d_next;
            mem_read_reg      <= mem_read_next;
            mem_write_reg     <= mem_write_next;
            reg_write_reg     <= reg_write_next;
            reg_dst_reg       <= reg_dst_next;
            mem_to_reg_reg    <= mem_to_reg_next;
            alu_src_a_reg     <= alu_src_a_next;
            alu_src_b_reg     <= alu_src_b_next;
            alu_op_reg        <= alu_op_next;
            instr_done_reg    <= instr_done_next;
            bus_err_reg       <= bus_err_next;
        end
    end

    // Handshake-completion terms; stall outranks mem_ready.
    logic fetch_done, wr_done;
    assign fetch_done = (state_reg == S_FETCH)  && mem_ready && !stall;
    assign wr_done    = (state_reg == S_MEM_WR) && mem_ready && !stall;

    assign pc_write      = (pc_write_reg && !stall) || fetch_done;
    assign pc_write_cond = pc_write_cond_reg && !stall;
    assign pc_en         = pc_write || (pc_write_cond && zero);
    assign pc_src        = pc_src_reg;
    assign i_or_d        = i_or_d_reg;
    assign ir_write      = fetch_done;
    assign mem_read      = mem_read_reg && !stall;
    assign mem_write     = mem_write_reg && !stall;
    assign reg_write     = reg_write_reg && !stall;
    assign reg_dst       = reg_dst_reg;
    assign mem_to_reg    = mem_to_reg_reg;
    assign alu_src_a     = alu_src_a_reg;
    assign alu_src_b     = alu_src_b_reg;
    assign alu_op        = alu_op_reg;
    assign instr_done    = (instr_done_reg && !stall) || wr_done;
    assign bus_err       = bus_err_reg;
    assign state_o       = state_reg;

`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt_reg, instr_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg <= 32'd0;
            instr_cnt_reg <= 32'd0;
        end else begin
            if (!stall && (state_reg != S_ERR)) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
            if (instr_done)                     instr_cnt_reg <= instr_cnt_reg + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_reg;
    assign instr_cnt = instr_cnt_reg;
`else
    // Performance counters not built.
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: directed instructions from the test plan,
// then randomized instruction streams with random memory waits and stalls.
// Expected outputs come from a per-instruction step list (which states an
// opcode visits, with wait/stall cycles) and a per-step output table.

module tb_multicycle_ctrl_fsm;

    localparam int MEM_TIMEOUT = 4;

    localparam logic [3:0] P_IDLE = 4'd0,  P_FETCH = 4'd1,  P_DECODE = 4'd2,
                           P_MEM_ADDR = 4'd3, P_MEM_RD = 4'd4, P_MEM_WB = 4'd5,
                           P_MEM_WR = 4'd6, P_EXEC_R = 4'd7, P_R_WB = 4'd8,
                           P_EXEC_I = 4'd9, P_I_WB = 4'd10, P_BRANCH = 4'd11,
                           P_JUMP = 4'd12, P_JAL = 4'd13, P_ERR = 4'd14;

    typedef struct packed {
        logic [3:0] state;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       bus_err;
    } out_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero, mem_ready, stall;
    logic       pc_write, pc_write_cond, pc_en, i_or_d, ir_write;
    logic       mem_read, mem_write, reg_write, alu_src_a, instr_done, bus_err;
    logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0] state_o;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .stall(stall),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en),
        .pc_src(pc_src), .i_or_d(i_or_d), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .instr_done(instr_done),
        .bus_err(bus_err),
`ifdef PERF_CNT_EN
        .state_o(state_o), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`else
        .state_o(state_o)
`endif
    );

    out_t obs;
    assign obs = {state_o, pc_write, pc_write_cond, pc_en, pc_src, i_or_d, ir_write,
                  mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, instr_done, bus_err};

    int checks = 0;
    int errors = 0;
    int cyc_model = 0;
    int ins_model = 0;
    int stall_pct = 0;
    int forced_wr_stalls = 0;
    int zero_mode = 2;      // 0/1 = fixed zero flag, 2 = random

    // Output table for one cycle spent in phase ph.
    function automatic out_t model(input logic [3:0] ph, input logic [2:0] op,
                                   input logic rdy, input logic stl, input logic z);
        out_t o;
        o = '0;
        o.state = ph;
        case (ph)
            P_FETCH: begin
                o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.alu_op = 2'b11;
                o.ir_write = rdy;  o.pc_write = rdy;
            end
            P_DECODE:   begin o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
            P_MEM_ADDR: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; o.alu_op = 2'b11; end
            P_MEM_RD:   begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
            P_MEM_WB:   begin o.reg_write = 1'b1; o.mem_to_reg = 2'b01; o.instr_done = 1'b1; end
            P_MEM_WR:   begin o.mem_write = 1'b1; o.i_or_d = 1'b1; o.instr_done = rdy; end
            P_EXEC_R:   o.alu_src_a = 1'b1;
            P_R_WB:     begin o.reg_write = 1'b1; o.reg_dst = 2'b01; o.instr_done = 1'b1; end
            P_EXEC_I: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                o.alu_op = (op == 3'b001) ? 2'b10 : 2'b11;
            end
            P_I_WB:     begin o.reg_write = 1'b1; o.instr_done = 1'b1; end
            P_BRANCH: begin
                o.alu_src_a = 1'b1; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                o.pc_src = 2'b01;   o.instr_done = 1'b1;
            end
            P_JUMP:     begin o.pc_write = 1'b1; o.pc_src = 2'b10; o.instr_done = 1'b1; end
            P_JAL: begin
                o.pc_write = 1'b1; o.pc_src = 2'b10; o.reg_write = 1'b1;
                o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.instr_done = 1'b1;
            end
            P_ERR:      o.bus_err = 1'b1;
            default:    ;
        endcase
        if (stl) begin
            o.pc_write = 1'b0; o.pc_write_cond = 1'b0; o.ir_write = 1'b0;
            o.reg_write = 1'b0; o.mem_write = 1'b0; o.mem_read = 1'b0;
            o.instr_done = 1'b0;
        end
        o.pc_en = o.pc_write | (o.pc_write_cond & z);
        return o;
    endfunction

    task automatic check_out(input string tag, input out_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%h expected=%h (state %0d vs %0d)",
                   tag, $time, obs, exp, obs.state, exp.state);
        end
    endtask

    // One clock: drive inputs, check just after, then advance to the next negedge.
    task automatic do_cycle(input logic [3:0] ph, input logic [2:0] op_lat,
                            input logic rdy, input logic stl,
                            input logic [2:0] opc_in, input string tag);
        out_t exp;
        mem_ready = rdy;
        stall     = stl;
        opcode    = opc_in;
        zero      = (zero_mode == 2) ? 1'($urandom_range(1)) : (zero_mode == 1);
        #1;
        exp = model(ph, op_lat, rdy, stl, zero);
        check_out($sformatf("%s ph%0d op%0d", tag, ph, op_lat), exp);
        if (!stl && ph != P_ERR) cyc_model++;
        if (exp.instr_done) ins_model++;
        @(negedge clk);
    endtask

    // One phase of an instruction, including optional stalls and memory waits.
    task automatic do_phase(input logic [3:0] ph, input logic [2:0] op,
                            input int waits, input int forced);
        bit waiting;
        int total;
        waiting = (ph == P_FETCH) || (ph == P_MEM_RD) || (ph == P_MEM_WR);
        total   = waiting ? waits + 1 : 1;
        for (int k = 0; k < total; k++) begin
            int ns;
            logic rdy;
            ns = ($urandom_range(99) < stall_pct) ? $urandom_range(2, 1) : 0;
            if (k == 0 && forced > 0) ns = forced;
            for (int s = 0; s < ns; s++)
                do_cycle(ph, op, (k == 0 && forced > 0) ? 1'b1 : 1'($urandom_range(1)),
                         1'b1, 3'($urandom_range(7)), "stall");
            rdy = waiting ? (k == total - 1) : 1'($urandom_range(1));
            do_cycle(ph, op, rdy, 1'b0, (ph == P_DECODE) ? op : 3'($urandom_range(7)), "step");
        end
    endtask

    task automatic run_instr(input logic [2:0] op, input int fwait, input int mwait);
        do_phase(P_FETCH, op, fwait, 0);
        do_phase(P_DECODE, op, 0, 0);
        case (op)
            3'b100: begin
                do_phase(P_MEM_ADDR, op, 0, 0);
                do_phase(P_MEM_RD, op, mwait, 0);
                do_phase(P_MEM_WB, op, 0, 0);
            end
            3'b101: begin
                do_phase(P_MEM_ADDR, op, 0, 0);
                do_phase(P_MEM_WR, op, mwait, forced_wr_stalls);
            end
            3'b000: begin do_phase(P_EXEC_R, op, 0, 0); do_phase(P_R_WB, op, 0, 0); end
            3'b111, 3'b001: begin do_phase(P_EXEC_I, op, 0, 0); do_phase(P_I_WB, op, 0, 0); end
            3'b110: do_phase(P_BRANCH, op, 0, 0);
            3'b010: do_phase(P_JUMP, op, 0, 0);
            default: do_phase(P_JAL, op, 0, 0);
        endcase
`ifdef PERF_CNT_EN
        checks++;
        assert (cycle_cnt === 32'(cyc_model)) else begin
            errors++;
            $error("FAIL cycle_cnt observed=%0d expected=%0d", cycle_cnt, cyc_model);
        end
        checks++;
        assert (instr_cnt === 32'(ins_model)) else begin
            errors++;
            $error("FAIL instr_cnt observed=%0d expected=%0d", instr_cnt, ins_model);
        end
`endif
    endtask

    // Asynchronous reset pulse: outputs must clear immediately and stay clear.
    task automatic do_reset();
        mem_ready = 1'b1;
        stall     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_out("reset_async", model(P_IDLE, 3'b000, 1'b0, 1'b0, zero));
        @(negedge clk);
        #1;
        check_out("reset_hold", model(P_IDLE, 3'b000, 1'b0, 1'b0, zero));
        @(negedge clk);
        rst_n     = 1'b1;
        cyc_model = 0;
        ins_model = 0;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 3'b000; zero = 1'b0; mem_ready = 1'b0; stall = 1'b0;
        #1;
        check_out("reset", model(P_IDLE, 3'b000, 1'b0, 1'b0, zero));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_cycle(P_IDLE, 3'b000, 1'b1, 1'b0, 3'b000, "idle");

        // addi, zero-wait memory: FETCH, DECODE, EXEC_I, I_WB
        run_instr(3'b111, 0, 0);
        // lw with three wait cycles in MEM_RD
        run_instr(3'b100, 0, 3);
        // beq taken / not taken
        zero_mode = 1; run_instr(3'b110, 0, 0);
        zero_mode = 0; run_instr(3'b110, 0, 0);
        zero_mode = 2;
        // jal
        run_instr(3'b011, 0, 0);
        // sw stalled for two cycles in MEM_WR with mem_ready high during the stall
        forced_wr_stalls = 2; run_instr(3'b101, 0, 0); forced_wr_stalls = 0;

        // Random instruction stream; waits stay below the timeout
        stall_pct = 20;
        repeat (150) run_instr(3'($urandom_range(7)), $urandom_range(3), $urandom_range(3));
        stall_pct = 0;

        // Timeout in FETCH: a stalled cycle with mem_ready high does not count or complete
        do_cycle(P_FETCH, 3'b000, 1'b0, 1'b0, 3'($urandom_range(7)), "to_wait1");
        do_cycle(P_FETCH, 3'b000, 1'b1, 1'b1, 3'($urandom_range(7)), "to_stall");
        do_cycle(P_FETCH, 3'b000, 1'b0, 1'b0, 3'($urandom_range(7)), "to_wait2");
        do_cycle(P_FETCH, 3'b000, 1'b0, 1'b0, 3'($urandom_range(7)), "to_wait3");
        do_cycle(P_FETCH, 3'b000, 1'b0, 1'b0, 3'($urandom_range(7)), "to_wait4");
        repeat (4) do_cycle(P_ERR, 3'b000, 1'($urandom_range(1)), 1'($urandom_range(1)),
                            3'($urandom_range(7)), "err");
        do_reset();
        do_cycle(P_IDLE, 3'b000, 1'b1, 1'b0, 3'b000, "idle2");

        // Reset in the middle of a lw while MEM_RD is driving the memory
        do_phase(P_FETCH, 3'b100, 1, 0);
        do_phase(P_DECODE, 3'b100, 0, 0);
        do_phase(P_MEM_ADDR, 3'b100, 0, 0);
        mem_ready = 1'b0; stall = 1'b0;
        #1;
        check_out("pre_rst", model(P_MEM_RD, 3'b100, 1'b0, 1'b0, zero));
        do_reset();
        do_cycle(P_IDLE, 3'b000, 1'b1, 1'b0, 3'b000, "idle3");
        run_instr(3'b001, 1, 0);
        run_instr(3'b000, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 16-bit MIPS core. It replaces single-cycle opcode decoding with a Moore/Mealy FSM.
- It steps the shared datapath (one memory port, one ALU, register file) through FETCH/DECODE/EXECUTE/MEM/WB for each 3-bit opcode.
- It stalls on a memory ready handshake and flags a bus error on memory timeout.
- It sits between the instruction register and the datapath mux/enable inputs.

Parameters:
- MEM_TIMEOUT, 16: max cycles waiting for mem_ready in FETCH, MEM_RD or MEM_WR before error. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. MEM_TIMEOUT must be less than 2^TO_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  3  IR[15:13]. Sampled only in DECODE.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the access this cycle.
- stall  in  1  freeze request from the debug/host side.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero.
- pc_en  out  1  pc_write | (pc_write_cond & zero).
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut.
- ir_write  out  1  load the IR.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  00 rt, 01 rd, 10 r7 (link).
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC.
- alu_src_a  out  1  0 = PC, 1 = rs.
- alu_src_b  out  2  00 rt, 01 +1 increment, 10 sign-extended immediate.
- alu_op  out  2  00 funct, 01 sub, 10 slt, 11 add.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- bus_err  out  1  sticky memory-timeout error.
- state_o  out  4  current state, for debug.

Behaviour:
- State register
  - Resets asynchronously to IDLE. All outputs are 0 while rst_n is 0 and while in IDLE.
  - IDLE -> FETCH unconditionally on the next clock.
  - Reset mid-instruction abandons the instruction; no write enable is asserted after rst_n falls.
- Opcode map: 000 R, 001 slti, 010 j, 011 jal, 100 lw, 101 sw, 110 beq, 111 addi.
- FETCH
  - Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=11.
  - While mem_ready=0, stays in FETCH.
  - On mem_ready=1 (Mealy), asserts ir_write=1 and pc_write=1 with pc_src=00, then goes to DECODE.
- DECODE
  - Asserts alu_src_a=0, alu_src_b=10, alu_op=11 (precompute branch target).
  - Next state by opcode: 100/101 -> MEM_ADDR; 000 -> EXEC_R; 111/001 -> EXEC_I; 110 -> BRANCH; 010 -> JUMP; 011 -> JAL.
- MEM_ADDR
  - Asserts alu_src_a=1, alu_src_b=10, alu_op=11.
  - Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD
  - Asserts mem_read=1, i_or_d=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB
  - Asserts reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Goes to FETCH.
- MEM_WR
  - Asserts mem_write=1, i_or_d=1 for every waiting cycle.
  - On mem_ready=1, asserts instr_done=1 and goes to FETCH.
- EXEC_R
  - Asserts alu_src_a=1, alu_src_b=00, alu_op=00. Goes to R_WB.
- R_WB
  - Asserts reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Goes to FETCH.
- EXEC_I
  - Asserts alu_src_a=1, alu_src_b=10, alu_op=11 for addi or 10 for slti.
  - The opcode is latched in DECODE into a 3-bit register, so a mid-instruction IR change is ignored. Goes to I_WB.
- I_WB
  - Asserts reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Goes to FETCH.
- BRANCH
  - Asserts alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, instr_done=1. Goes to FETCH.
- JUMP
  - Asserts pc_write=1, pc_src=10, instr_done=1. Goes to FETCH.
- JAL
  - Asserts pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1. Goes to FETCH.
- Latency: R/addi/slti 4 cycles, beq/j/jal 3, lw 5, sw 4 (zero-wait memory).
- stall=1
  - The state, latched opcode and timeout counter all hold.
  - Forced to 0: pc_write, pc_write_cond, pc_en, ir_write, reg_write, mem_write, mem_read, instr_done. Mux selects are unchanged.
  - stall has priority over mem_ready, so a mem_ready arriving during stall is ignored.
- Timeout
  - The counter clears on entry to FETCH, MEM_RD or MEM_WR and increments on each wait cycle with mem_ready=0.
  - When count reaches MEM_TIMEOUT (nonzero), the FSM goes to ERR.
  - ERR: all enables 0, bus_err=1. Exit only by reset.
- Unused state encodings go to IDLE on the next clock.

Optional Feature:
- Macro PERF_CNT_EN.
- When defined, adds output ports cycle_cnt[31:0] and instr_cnt[31:0], both reset to 0.
  - cycle_cnt increments every non-stalled, non-ERR cycle.
  - instr_cnt increments on each instr_done.
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then addi with mem_ready tied 1 -> state IDLE, FETCH, DECODE, EXEC_I, I_WB. reg_write=1 only in I_WB. instr_done is a single pulse at cycle 5.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read held 4 cycles with i_or_d=1. MEM_WB follows with mem_to_reg=01.
- beq with zero=1, then with zero=0 -> pc_en=1 and pc_en=0 respectively in BRANCH. Total 3 cycles each.
- jal -> in JAL: pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> ERR after 4 wait cycles. bus_err=1 stays set until rst_n pulse, with all enables 0.
- sw with stall=1 for 2 cycles in MEM_WR and mem_ready=1 during stall -> mem_write=0 and state held during stall. Completes on the first unstalled cycle. With PERF_CNT_EN defined, instr_cnt increments by 1.
